lfa_adc_reader: RTL and testbench

- Producer of the 12-bit `left`, `middle` and `right` line-sensor words consumed by the line-following controller.
- Drives the on-board ADC128S022 (8-channel, 12-bit, SPI-style) over CS_N/SCLK/DIN/DOUT.
- Continuously round-robins the three LFA channels and holds the latest reading for each in a register.
- Pulses `data_valid` once per complete left/middle/right set.

---
 rtl/lfa_adc_pkg.sv | 39 +++
 rtl/lfa_adc_reader_tick.sv | 35 +++
 rtl/lfa_adc_reader.sv | 184 ++++++++++++++++++
 tb/tb_lfa_adc_reader.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfa_adc_pkg.sv
// Shared types and constants for the LFA line-sensor ADC reader.
// Holds the sequencer states, the channel rotation and the control-word helper.
package lfa_adc_pkg;

   localparam int FRAME_CLKS     = 16;
   localparam int GAP_TICKS      = 3;
   localparam int RESULT_W       = 12;
   localparam int ADDR_W         = 3;
   localparam int FRAME_END_TICK = 2 * FRAME_CLKS + 1;
   localparam int PERIOD_TICKS   = FRAME_END_TICK + GAP_TICKS;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FRAME = 2'd1,
      GAP   = 2'd2
   } state_e;

   typedef enum logic [1:0] {
      SEL_LEFT  = 2'd0,
      SEL_MID   = 2'd1,
      SEL_RIGHT = 2'd2
   } sel_e;

   function automatic sel_e next_sel(input sel_e s);
      case (s)
         SEL_LEFT: return SEL_MID;
         SEL_MID:  return SEL_RIGHT;
         default:  return SEL_LEFT;
      endcase
   endfunction

   // Bit for SCLK clock (sclk_idx+1) of {2'b00, addr, 3'b000} followed by eight zeros, MSB first.
   function automatic logic ctrl_bit(input logic [ADDR_W-1:0] addr, input logic [3:0] sclk_idx);
      logic [15:0] word;
      word = {2'b00, addr, 3'b000, 8'h00};
      return word[4'd15 - sclk_idx];
   endfunction

endpackage

// File: rtl/lfa_adc_reader_tick.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 and pulses tick_o on the last count.
// clr_i restarts the count so the first frame edge lands a fixed distance after T0.
module lfa_adc_tick #(
   parameter int CLK_DIV = 25
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic clr_i,
   output logic tick_o
);

   localparam int CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   assign tick_o = (cnt_q == LAST);

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/lfa_adc_reader.sv
// ADC128S022 sequencer: round-robins left/middle/right channels and keeps the latest result
// of each. The ADC returns data one frame late, so each result goes to the previous frame's channel.
module lfa_adc_reader
   import lfa_adc_pkg::*;
#(
   parameter int                CLK_DIV  = 25,
   parameter logic [ADDR_W-1:0] CH_LEFT  = 3'd3,
   parameter logic [ADDR_W-1:0] CH_MID   = 3'd2,
   parameter logic [ADDR_W-1:0] CH_RIGHT = 3'd1
) (
   input  logic                clk_50M,
   input  logic                rst_n,
   input  logic                en,
   output logic                adc_cs_n,
   output logic                adc_sck,
   output logic                adc_din,
   input  logic                adc_dout,
   output logic [RESULT_W-1:0] left,
   output logic [RESULT_W-1:0] middle,
   output logic [RESULT_W-1:0] right,
   output logic                data_valid,
   output logic                busy
);

   state_e              state_q,  state_d;
   sel_e                rot_q,    rot_d;
   sel_e                prev_q,   prev_d;
   logic                primed_q, primed_d;
   logic [5:0]          tcnt_q,   tcnt_d;
   logic                cs_n_q,   cs_n_d;
   logic                sck_q,    sck_d;
   logic                din_q,    din_d;
   logic [RESULT_W-1:0] shreg_q,  shreg_d;
   logic [RESULT_W-1:0] left_q,   left_d;
   logic [RESULT_W-1:0] mid_q,    mid_d;
   logic [RESULT_W-1:0] right_q,  right_d;
   logic                dv_q,     dv_d;
   logic                tick;
   logic                tick_clr;
   logic [5:0]          k;

   function automatic logic [ADDR_W-1:0] sel_addr(input sel_e s);
      case (s)
         SEL_LEFT: return CH_LEFT;
         SEL_MID:  return CH_MID;
         default:  return CH_RIGHT;
      endcase
   endfunction

   lfa_adc_tick #(
      .CLK_DIV (CLK_DIV)
   ) u_tick (
      .clk_i   (clk_50M),
      .rst_n_i (rst_n),
      .clr_i   (tick_clr),
      .tick_o  (tick)
   );

   assign k = tcnt_q + 6'd1;

   always_comb begin
      state_d  = state_q;
      rot_d    = rot_q;
      prev_d   = prev_q;
      primed_d = primed_q;
      tcnt_d   = tcnt_q;
      cs_n_d   = cs_n_q;
      sck_d    = sck_q;
      din_d    = din_q;
      shreg_d  = shreg_q;
      left_d   = left_q;
      mid_d    = mid_q;
      right_d  = right_q;
      dv_d     = 1'b0;
      tick_clr = 1'b0;

      case (state_q)
         IDLE: begin
            if (tick && en) begin
               state_d  = FRAME;
               cs_n_d   = 1'b0;
               primed_d = 1'b0;
               rot_d    = SEL_LEFT;
               tcnt_d   = '0;
               tick_clr = 1'b1;
            end
         end

         FRAME: begin
            if (tick) begin
               tcnt_d = k;
               if (k == 6'(FRAME_END_TICK)) begin
                  // Only 12 bits are kept; the four leading zero bits have already shifted out.
                  cs_n_d = 1'b1;
                  if (primed_q) begin
                     case (prev_q)
                        SEL_LEFT: left_d = shreg_q;
                        SEL_MID:  mid_d  = shreg_q;
                        default: begin
                           right_d = shreg_q;
                           dv_d    = 1'b1;
                        end
                     endcase
                  end
                  primed_d = 1'b1;
                  prev_d   = rot_q;
                  rot_d    = next_sel(rot_q);
                  state_d  = GAP;
               end else if (k[0]) begin
                  sck_d = 1'b0;
                  din_d = ctrl_bit(sel_addr(rot_q), k[4:1]);
               end else begin
                  sck_d   = 1'b1;
                  shreg_d = {shreg_q[RESULT_W-2:0], adc_dout};
               end
            end
         end

         GAP: begin
            if (tick) begin
               if (k == 6'(PERIOD_TICKS)) begin
                  tcnt_d = '0;
                  if (en) begin
                     state_d = FRAME;
                     cs_n_d  = 1'b0;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  tcnt_d = k;
               end
            end
         end

         default: begin
            state_d = IDLE;
            cs_n_d  = 1'b1;
            sck_d   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rot_q    <= SEL_LEFT;
         prev_q   <= SEL_LEFT;
         primed_q <= 1'b0;
         tcnt_q   <= '0;
         cs_n_q   <= 1'b1;
         sck_q    <= 1'b1;
         din_q    <= 1'b0;
         shreg_q  <= '0;
         left_q   <= '0;
         mid_q    <= '0;
         right_q  <= '0;
         dv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         rot_q    <= rot_d;
         prev_q   <= prev_d;
         primed_q <= primed_d;
         tcnt_q   <= tcnt_d;
         cs_n_q   <= cs_n_d;
         sck_q    <= sck_d;
         din_q    <= din_d;
         shreg_q  <= shreg_d;
         left_q   <= left_d;
         mid_q    <= mid_d;
         right_q  <= right_d;
         dv_q     <= dv_d;
      end
   end

   assign adc_cs_n   = cs_n_q;
   assign adc_sck    = sck_q;
   assign adc_din    = din_q;
   assign left       = left_q;
   assign middle     = mid_q;
   assign right      = right_q;
   assign data_valid = dv_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lfa_adc_reader.sv
// Directed bench for lfa_adc_reader with a behavioural ADC128S022 model.
// Each task drives one scenario and checks against hand-computed values.
module tb_lfa_adc_reader;

   logic        clk_50M = 1'b0;
   logic        rst_n   = 1'b0;
   logic        en      = 1'b0;
   logic        adc_cs_n;
   logic        adc_sck;
   logic        adc_din;
   logic        adc_dout = 1'b0;
   logic [11:0] left;
   logic [11:0] middle;
   logic [11:0] right;
   logic        data_valid;
   logic        busy;

   int tests_run    = 0;
   int tests_failed = 0;

   lfa_adc_reader #(
      .CLK_DIV  (25),
      .CH_LEFT  (3'd3),
      .CH_MID   (3'd2),
      .CH_RIGHT (3'd1)
   ) dut (
      .clk_50M    (clk_50M),
      .rst_n      (rst_n),
      .en         (en),
      .adc_cs_n   (adc_cs_n),
      .adc_sck    (adc_sck),
      .adc_din    (adc_din),
      .adc_dout   (adc_dout),
      .left       (left),
      .middle     (middle),
      .right      (right),
      .data_valid (data_valid),
      .busy       (busy)
   );

   always #10 clk_50M = ~clk_50M;

   // ADC model and bus monitor
   logic [11:0] ch_data [0:7];
   logic [15:0] din_log [0:255];
   logic [15:0] din_sh    = '0;
   logic [15:0] dout_word = '0;
   logic [2:0]  pending   = 3'd0;
   int cyc = 0, frame_starts = 0, frames_done = 0, n_fall = 0;
   int fall_cyc = 0, last_fall_cyc = 0;
   int low_len = 0, period = 0, sck_period = 0, falls_in_win = 0;

   always @(posedge clk_50M) cyc++;

   always @(negedge adc_cs_n) begin
      period    = cyc - fall_cyc;
      fall_cyc  = cyc;
      n_fall    = 0;
      din_sh    = '0;
      dout_word = {4'b0000, ch_data[pending]};
      frame_starts++;
   end

   always @(negedge adc_sck) begin
      if (adc_cs_n === 1'b0) begin
         n_fall++;
         if (n_fall >= 2) sck_period = cyc - last_fall_cyc;
         last_fall_cyc = cyc;
         if (n_fall <= 16) adc_dout = dout_word[16-n_fall];
      end
   end

   always @(posedge adc_sck) begin
      if (adc_cs_n === 1'b0) din_sh = {din_sh[14:0], adc_din};
   end

   always @(posedge adc_cs_n) begin
      low_len      = cyc - fall_cyc;
      falls_in_win = n_fall;
      din_log[frames_done[7:0]] = din_sh;
      pending      = din_sh[13:11];
      frames_done++;
   end

   task automatic wait_dv(input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_50M);
         if (data_valid === 1'b1) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_cs_fall(input int max_cyc, output bit ok);
      int s0;
      s0 = frame_starts;
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_50M);
         if (frame_starts != s0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_sclk(input int n, input int max_cyc, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max_cyc; i++) begin
         @(negedge clk_50M);
         if (n_fall >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      en    = 1'b0;
      repeat (5) @(negedge clk_50M);
      tests_run++; if (adc_cs_n !== 1'b1) begin tests_failed++; $display("FAIL reset_cs_n: got %b want 1", adc_cs_n); end
      tests_run++; if (adc_sck !== 1'b1) begin tests_failed++; $display("FAIL reset_sck: got %b want 1", adc_sck); end
      tests_run++; if (adc_din !== 1'b0) begin tests_failed++; $display("FAIL reset_din: got %b want 0", adc_din); end
      tests_run++; if ({left, middle, right} !== 36'h0) begin tests_failed++; $display("FAIL reset_results: got %h %h %h want 000 000 000", left, middle, right); end
      tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_dv: got %b want 0", data_valid); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
      $display("[TB] reset: cs_n=%b sck=%b busy=%b", adc_cs_n, adc_sck, busy);
   endtask

   task automatic test_first_set();
      int base, base_done;
      bit ok;
      base      = frame_starts;
      base_done = frames_done;
      en    = 1'b1;
      rst_n = 1'b1;
      wait_dv(5000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL first_dv_timeout: got none want pulse within 5000 clks"); end
      tests_run++; if (frame_starts - base !== 4) begin tests_failed++; $display("FAIL first_dv_frames: got %0d want 4", frame_starts - base); end
      tests_run++; if (left !== 12'h4B0) begin tests_failed++; $display("FAIL first_left: got %h want 4b0", left); end
      tests_run++; if (middle !== 12'h9C4) begin tests_failed++; $display("FAIL first_middle: got %h want 9c4", middle); end
      tests_run++; if (right !== 12'h2BC) begin tests_failed++; $display("FAIL first_right: got %h want 2bc", right); end
      $display("[TB] first set: frames=%0d L=%h M=%h R=%h", frame_starts - base, left, middle, right);
      @(negedge clk_50M);
      tests_run++; if (data_valid !== 1'b0) begin tests_failed++; $display("FAIL dv_width: got %b want 0", data_valid); end
      tests_run++; if (din_log[base_done[7:0]] !== 16'h1800) begin tests_failed++; $display("FAIL din_frame0: got %h want 1800", din_log[base_done[7:0]]); end
      tests_run++; if (din_log[8'(base_done + 1)] !== 16'h1000) begin tests_failed++; $display("FAIL din_frame1: got %h want 1000", din_log[8'(base_done + 1)]); end
      tests_run++; if (din_log[8'(base_done + 2)] !== 16'h0800) begin tests_failed++; $display("FAIL din_frame2: got %h want 0800", din_log[8'(base_done + 2)]); end
      tests_run++; if (din_log[8'(base_done + 3)] !== 16'h1800) begin tests_failed++; $display("FAIL din_frame3: got %h want 1800", din_log[8'(base_done + 3)]); end
      $display("[TB] din: %h %h %h %h", din_log[base_done[7:0]], din_log[8'(base_done + 1)], din_log[8'(base_done + 2)], din_log[8'(base_done + 3)]);
      base = frame_starts;
      wait_dv(3000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL second_dv_timeout: got none want pulse within 3000 clks"); end
      tests_run++; if (frame_starts - base !== 3) begin tests_failed++; $display("FAIL dv_spacing: got %0d want 3 frames", frame_starts - base); end
      $display("[TB] second set: frames=%0d", frame_starts - base);
   endtask

   task automatic test_timing();
      int d0;
      bit ok;
      d0 = frames_done;
      ok = 1'b0;
      for (int i = 0; i < 2500; i++) begin
         @(negedge clk_50M);
         if (frames_done - d0 >= 2) begin ok = 1'b1; break; end
      end
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL timing_timeout: got no frames want 2"); end
      tests_run++; if (low_len !== 825) begin tests_failed++; $display("FAIL cs_low_len: got %0d want 825", low_len); end
      tests_run++; if (falls_in_win !== 16) begin tests_failed++; $display("FAIL sck_falls: got %0d want 16", falls_in_win); end
      tests_run++; if (sck_period !== 50) begin tests_failed++; $display("FAIL sck_period: got %0d want 50", sck_period); end
      tests_run++; if (period !== 900) begin tests_failed++; $display("FAIL frame_period: got %0d want 900", period); end
      $display("[TB] timing: low=%0d falls=%0d sck=%0d period=%0d", low_len, falls_in_win, sck_period, period);
   endtask

   task automatic test_mid_change();
      bit ok1, ok2;
      ch_data[2] = 12'hFFF;
      wait_dv(3000, ok1);
      wait_dv(3000, ok2);
      tests_run++; if (!(ok1 && ok2)) begin tests_failed++; $display("FAIL mid_change_timeout: got %b%b want 11", ok1, ok2); end
      tests_run++; if (middle !== 12'hFFF) begin tests_failed++; $display("FAIL mid_change_middle: got %h want fff", middle); end
      tests_run++; if (left !== 12'h4B0) begin tests_failed++; $display("FAIL mid_change_left: got %h want 4b0", left); end
      tests_run++; if (right !== 12'h2BC) begin tests_failed++; $display("FAIL mid_change_right: got %h want 2bc", right); end
      $display("[TB] mid change: L=%h M=%h R=%h", left, middle, right);
   endtask

   task automatic test_en_drop();
      bit ok;
      int s0, d0, base, base_done;
      // Called right after a data_valid: the next frame returns left-channel data.
      ch_data[3] = 12'h555;
      wait_cs_fall(1000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL drop_cs_timeout: got none want frame start"); end
      wait_sclk(8, 1000, ok);
      en = 1'b0;
      d0 = frames_done;
      for (int i = 0; i < 1000; i++) begin
         @(negedge clk_50M);
         if (frames_done != d0) break;
      end
      @(negedge clk_50M);
      tests_run++; if (left !== 12'h555) begin tests_failed++; $display("FAIL drop_left_written: got %h want 555", left); end
      tests_run++; if (middle !== 12'hFFF) begin tests_failed++; $display("FAIL drop_middle: got %h want fff", middle); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL drop_busy_in_gap: got %b want 1", busy); end
      repeat (100) @(negedge clk_50M);
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy_after_gap: got %b want 0", busy); end
      s0 = frame_starts;
      repeat (2000) @(negedge clk_50M);
      tests_run++; if (frame_starts !== s0 || adc_cs_n !== 1'b1) begin tests_failed++; $display("FAIL drop_cs_idle: got starts+%0d cs_n=%b want +0 1", frame_starts - s0, adc_cs_n); end
      $display("[TB] en drop: L=%h busy=%b cs_n=%b", left, busy, adc_cs_n);
      base      = frame_starts;
      base_done = frames_done;
      en = 1'b1;
      wait_dv(5000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL restart_dv_timeout: got none want pulse"); end
      tests_run++; if (frame_starts - base !== 4) begin tests_failed++; $display("FAIL restart_frames: got %0d want 4", frame_starts - base); end
      tests_run++; if (din_log[base_done[7:0]] !== 16'h1800) begin tests_failed++; $display("FAIL restart_din0: got %h want 1800", din_log[base_done[7:0]]); end
      tests_run++; if ({left, middle, right} !== {12'h555, 12'hFFF, 12'h2BC}) begin tests_failed++; $display("FAIL restart_values: got %h %h %h want 555 fff 2bc", left, middle, right); end
      $display("[TB] restart: frames=%0d L=%h M=%h R=%h", frame_starts - base, left, middle, right);
   endtask

   task automatic test_reset_mid();
      bit ok;
      int base;
      wait_cs_fall(1000, ok);
      wait_sclk(10, 1000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_sclk_timeout: got %0d falls want 10", n_fall); end
      #3 rst_n = 1'b0;
      #1;
      tests_run++; if (adc_cs_n !== 1'b1 || adc_sck !== 1'b1) begin tests_failed++; $display("FAIL rstmid_bus: got cs_n=%b sck=%b want 1 1", adc_cs_n, adc_sck); end
      tests_run++; if ({left, middle, right} !== 36'h0) begin tests_failed++; $display("FAIL rstmid_results: got %h %h %h want 000 000 000", left, middle, right); end
      tests_run++; if (busy !== 1'b0 || data_valid !== 1'b0) begin tests_failed++; $display("FAIL rstmid_status: got busy=%b dv=%b want 0 0", busy, data_valid); end
      $display("[TB] async reset: cs_n=%b sck=%b L=%h", adc_cs_n, adc_sck, left);
      repeat (3) @(negedge clk_50M);
      base  = frame_starts;
      rst_n = 1'b1;
      wait_dv(5000, ok);
      tests_run++; if (!ok) begin tests_failed++; $display("FAIL rstmid_dv_timeout: got none want pulse"); end
      tests_run++; if (frame_starts - base !== 4) begin tests_failed++; $display("FAIL rstmid_frames: got %0d want 4", frame_starts - base); end
      tests_run++; if ({left, middle, right} !== {12'h555, 12'hFFF, 12'h2BC}) begin tests_failed++; $display("FAIL rstmid_values: got %h %h %h want 555 fff 2bc", left, middle, right); end
      $display("[TB] after reset: frames=%0d L=%h M=%h R=%h", frame_starts - base, left, middle, right);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) ch_data[i] = 12'h0A5;
      ch_data[3] = 12'h4B0;
      ch_data[2] = 12'h9C4;
      ch_data[1] = 12'h2BC;
      test_reset();
      test_first_set();
      test_timing();
      test_mid_change();
      test_en_drop();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
